// File: rtl/can_ctrl_pkg.sv
// Shared types and constants for the CAN channel control path.
package can_ctrl_pkg;

  localparam int unsigned CAN_EOF_BITS  = 7;
  localparam int unsigned CAN_IDLE_BITS = 11;
  localparam int unsigned CAN_TAIL_BITS = 18;
  localparam int unsigned CAN_MAX_BYTES = 8;
  localparam int unsigned RUN_CNT_W     = 8;

  typedef enum logic [2:0] {
    S_DETRST,
    S_IDLE,
    S_ARMED,
    S_SOF,
    S_HEADER,
    S_PAYLOAD,
    S_EOF
  } seq_state_t;

  // Classic CAN: DLC codes 9..15 still carry 8 data bytes.
  function automatic logic [3:0] dlcToBytes(input logic [3:0] dlc);
    return (dlc > 4'(CAN_MAX_BYTES)) ? 4'(CAN_MAX_BYTES) : dlc;
  endfunction

endpackage

// File: rtl/can_frame_sequencer_bit_run_counter.sv
// Counts consecutive recessive (bitIn=1) samples; a dominant sample or clear restarts the run.
module bit_run_counter
  import can_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = RUN_CNT_W
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             bitTick,
  input  logic             bitIn,
  input  logic             clear,
  input  logic [CNT_W-1:0] target,
  output logic             reached
);

  logic [CNT_W-1:0] runCnt;
  logic [CNT_W-1:0] cntInc;

  // Saturating increment so a long idle bus cannot wrap the run length.
  always_comb begin
    cntInc = runCnt;
    if (runCnt != '1) begin
      cntInc = runCnt + CNT_W'(1);
    end
  end

  // Run length and reached flag move together so reached is valid with the count.
  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      runCnt  <= '0;
      reached <= 1'b0;
    end else if (bitTick) begin
      if (bitIn) begin
        runCnt  <= cntInc;
        reached <= (cntInc >= target);
      end else begin
        runCnt  <= '0;
        reached <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/can_frame_sequencer.sv
// Frame-level sequencer for the CAN size detector: idle qualify, SOF arm, DLC latch, EOF close.
module can_frame_sequencer
  import can_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_BITS      = CAN_IDLE_BITS,
  parameter int unsigned EOF_BITS       = CAN_EOF_BITS,
  parameter int unsigned TAIL_BITS      = CAN_TAIL_BITS,
  parameter int unsigned MAX_FRAME_BITS = 160
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       dIn,
  input  logic       bitTick,
  input  logic       cfgDone,
  input  logic [3:0] msgSizeIn,
  output logic       detEnable,
  output logic       detResetN,
  output logic       frameActive,
  output logic       frameDone,
  output logic [3:0] frameDlc,
  output logic [3:0] frameBytes,
  output logic       timeoutErr
);

  localparam int unsigned BIT_CNT_W      = 8;
  localparam int unsigned REM_CNT_W      = 7;
  localparam int unsigned DET_RST_CYCLES = 2;

  seq_state_t           state;
  logic                 dInQ;
  logic                 dInQQ;
  logic [BIT_CNT_W-1:0] bitCnt;
  logic [REM_CNT_W-1:0] remCnt;
  logic                 rstCnt;
  logic                 runClear;
  logic [RUN_CNT_W-1:0] runTarget;
  logic                 runReached;
  logic                 fallEdge;
  logic                 watchdogHit;
  logic [3:0]           dlcBytes;

  // Shared run counter: idle qualification in S_IDLE, end-of-frame in S_EOF, held clear otherwise.
  always_comb begin
    runClear    = !((state == S_IDLE) || (state == S_EOF));
    runTarget   = (state == S_EOF) ? RUN_CNT_W'(EOF_BITS) : RUN_CNT_W'(IDLE_BITS);
    fallEdge    = dInQQ & ~dInQ;
    watchdogHit = (bitCnt >= BIT_CNT_W'(MAX_FRAME_BITS));
    dlcBytes    = dlcToBytes(msgSizeIn);
  end

  bit_run_counter #(
    .CNT_W(RUN_CNT_W)
  ) uRunCounter (
    .clk    (clk),
    .resetN (resetN),
    .bitTick(bitTick),
    .bitIn  (dIn),
    .clear  (runClear),
    .target (runTarget),
    .reached(runReached)
  );

  // Two-stage bus history for recessive-to-dominant edge detection.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      dInQ  <= 1'b1;
      dInQQ <= 1'b1;
    end else begin
      dInQ  <= dIn;
      dInQQ <= dInQ;
    end
  end

  // Bit times since SOF confirmation, saturating; feeds the watchdog.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bitCnt <= '0;
    end else if ((state == S_SOF) && bitTick && !dIn) begin
      bitCnt <= '0;
    end else if (frameActive && bitTick && (bitCnt != '1)) begin
      bitCnt <= bitCnt + BIT_CNT_W'(1);
    end
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= S_DETRST;
      rstCnt      <= 1'b0;
      remCnt      <= '0;
      detEnable   <= 1'b0;
      detResetN   <= 1'b0;
      frameActive <= 1'b0;
      frameDone   <= 1'b0;
      frameDlc    <= '0;
      frameBytes  <= '0;
      timeoutErr  <= 1'b0;
    end else begin
      frameDone  <= 1'b0;
      timeoutErr <= 1'b0;
      case (state)
        S_DETRST: begin
          detEnable <= 1'b0;
          if (rstCnt == 1'(DET_RST_CYCLES - 1)) begin
            detResetN <= 1'b1;
            rstCnt    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            detResetN <= 1'b0;
            rstCnt    <= rstCnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (runReached) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (fallEdge) begin
            detEnable <= 1'b1;
            state     <= S_SOF;
          end
        end
        S_SOF: begin
          if (bitTick) begin
            if (!dIn) begin
              frameActive <= 1'b1;
              state       <= S_HEADER;
            end else begin
              timeoutErr <= 1'b1;
              detEnable  <= 1'b0;
              detResetN  <= 1'b0;
              rstCnt     <= 1'b0;
              state      <= S_DETRST;
            end
          end
        end
        S_HEADER, S_PAYLOAD, S_EOF: begin
          if (watchdogHit) begin
            timeoutErr  <= 1'b1;
            frameActive <= 1'b0;
            detEnable   <= 1'b0;
            detResetN   <= 1'b0;
            rstCnt      <= 1'b0;
            state       <= S_DETRST;
          end else if (state == S_HEADER) begin
            if (cfgDone) begin
              frameDlc   <= msgSizeIn;
              frameBytes <= dlcBytes;
              remCnt     <= REM_CNT_W'({dlcBytes, 3'b000}) + REM_CNT_W'(TAIL_BITS);
              state      <= S_PAYLOAD;
            end
          end else if (state == S_PAYLOAD) begin
            if (remCnt == '0) begin
              state <= S_EOF;
            end else if (bitTick) begin
              remCnt <= remCnt - REM_CNT_W'(1);
            end
          end else if (runReached) begin
            frameDone   <= 1'b1;
            frameActive <= 1'b0;
            detEnable   <= 1'b0;
            detResetN   <= 1'b0;
            rstCnt      <= 1'b0;
            state       <= S_DETRST;
          end
        end
        default: begin
          detEnable <= 1'b0;
          detResetN <= 1'b0;
          rstCnt    <= 1'b0;
          state     <= S_DETRST;
        end
      endcase
    end
  end

endmodule

// File: doc/can_frame_sequencer.md
# can_frame_sequencer

Controller that sequences the CAN size-detect datapath frame by frame. It qualifies bus idle and arms the detector on the SOF falling edge, then waits for the detector's configuration-complete flag and latches the DLC. It tracks the rest of the frame to end-of-frame and re-initialises the detector for the next frame. It sits between the bit-timing/sample logic and the size detector inside the channel unit.

## Interface
Parameters:
- IDLE_BITS, default 11: consecutive recessive bits required before arming.
- EOF_BITS, default 7: consecutive recessive bits that close a frame.
- TAIL_BITS, default 18: CRC (15) + CRC delimiter + ACK slot + ACK delimiter.
- MAX_FRAME_BITS, default 160: watchdog limit in bit times from SOF.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- resetN  in  1  synchronous, active-low reset.
- dIn  in  1  synchronised bus level; 1 = recessive.
- bitTick  in  1  one-cycle pulse at each final bit sample point.
- cfgDone  in  1  detector configuration-complete flag; level.
- msgSizeIn  in  4  DLC from detector; valid while cfgDone=1.
- detEnable  out  1  enable to detector.
- detResetN  out  1  active-low synchronous reset to detector.
- frameActive  out  1  high from SOF qualification to frame end.
- frameDone  out  1  one-cycle pulse at valid EOF.
- frameDlc  out  4  latched raw DLC.
- frameBytes  out  4  min(DLC, 8).
- timeoutErr  out  1  one-cycle pulse on watchdog expiry or glitch abort.

## Operation
State machine:
- S_DETRST: detResetN=0 for 2 cycles, then go to S_IDLE.
- S_IDLE: on bitTick, if dIn=1 increment runCnt, else clear it. When runCnt reaches IDLE_BITS, go to S_ARMED.
- S_ARMED: on registered dIn 1→0 edge, set detEnable=1 in the same cycle the edge is seen and go to S_SOF.
- S_SOF: on the first bitTick:
  - dIn=0: SOF is confirmed. Set frameActive=1, clear bitCnt, go to S_HEADER.
  - dIn=1: glitch. Pulse timeoutErr and go to S_DETRST.
- S_HEADER: hold detEnable. When cfgDone=1, latch frameDlc and frameBytes, load remCnt = frameBytes×8 + TAIL_BITS, go to S_PAYLOAD.
- S_PAYLOAD: decrement remCnt on each bitTick. At 0, clear runCnt and go to S_EOF.
- S_EOF: count consecutive recessive bits on bitTick. A dominant bit clears the count.
  - Count reaches EOF_BITS: pulse frameDone, clear frameActive, go to S_DETRST.

Counting rules:
- bitCnt (8 bits) increments on every bitTick while frameActive=1 and saturates at 255.
- Watchdog: if bitCnt ≥ MAX_FRAME_BITS in S_HEADER, S_PAYLOAD or S_EOF, pulse timeoutErr, clear frameActive, go to S_DETRST.
- Watchdog has priority over cfgDone and over EOF completion in the same cycle.
- DLC 9–15 gives frameBytes=8, with frameDlc holding the raw value.
- remCnt is 7 bits; its maximum value is 82.
- The controller makes no stuff-bit correction. bitTick counts all bits, so the payload count is nominal. EOF detection, which is stuff-free by protocol, is authoritative for frame end.

## Timing
- Reset values: detEnable=0, detResetN=0, frameActive=0, frameDone=0, frameDlc=0, frameBytes=0, timeoutErr=0, state=S_DETRST.
- All outputs are registered.
- detEnable rises 1 cycle after the dIn edge register captures the 1→0 edge. It falls on entry to S_DETRST.
- frameDlc and frameBytes update 1 cycle after cfgDone is first seen high in S_HEADER. They hold until the next latch and are not cleared by S_DETRST.
- frameDone and timeoutErr are exactly 1 cycle wide and never assert together.
- resetN low mid-frame: all outputs return to reset values on the next clk, with no frameDone or timeoutErr pulse.
- bitTick coincident with a state entry is consumed by the new state only from the next cycle.

## Structure
- Shared package can_ctrl_pkg holds:
  - the seq_state_t enum;
  - constants CAN_EOF_BITS=7, CAN_IDLE_BITS=11, CAN_TAIL_BITS=18, CAN_MAX_BYTES=8.
- One natural sub-module: bit_run_counter. It counts consecutive equal bits on bitTick, with clear input and reached-N flag, and is used for both idle and EOF detection.
- Edge detection and watchdog stay inline.

## Test plan
- Reset, 11 recessive bits, SOF, detector model returns cfgDone with DLC=4 → frameBytes=4, remCnt load=50, frameDone 1 cycle after the 7th EOF recessive bit, then detResetN low for 2 cycles.
- DLC=12 → frameDlc=12, frameBytes=8, remCnt load=82.
- dIn 1→0 edge in S_ARMED, but dIn=1 at the next bitTick → timeoutErr pulse, detEnable drops, return to S_DETRST.
- cfgDone never asserts → timeoutErr at bitCnt=160, frameActive=0, no frameDone.
- Only 10 recessive idle bits before a dominant bit → stays in S_IDLE and detEnable stays 0.
- resetN asserted during S_PAYLOAD → all outputs at reset values the next cycle; a full frame afterwards completes normally.
